// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller signal bundle between the pipeline and pipe_hazard_ctrl
interface pipe_hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_D;
    logic [4:0] wa_E;
    logic [4:0] wa_M;
    logic [4:0] wa_W;
    logic       we_E;
    logic       we_M;
    logic       we_W;
    logic [1:0] tnew_E;
    logic [1:0] tnew_M;
    logic       md_start_E;
    logic       md_div_E;
    logic       stall;
    logic       flush_E;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic       md_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        output wa_E, wa_M, wa_W, we_E, we_M, we_W, tnew_E, tnew_M,
        output md_start_E, md_div_E,
        input  stall, flush_E, fwd_rs_D, fwd_rt_D, md_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        input  wa_E, wa_M, wa_W, we_E, we_M, we_W, tnew_E, tnew_M,
        input  md_start_E, md_div_E,
        output stall, flush_E, fwd_rs_D, fwd_rt_D, md_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/forward decisions and mult/div busy sequencer for a 5-stage pipeline
// Optional stall_cnt output enabled by defining HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl (
    input  logic                clk,
    input  logic                clr_n,
    pipe_hazard_ctrl_if.slave   hif
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_t;

    md_state_t  r_state;
    md_state_t  w_state_nxt;
    logic [5:0] r_count;
    logic [5:0] w_count_nxt;

    logic w_haz_rs;
    logic w_haz_rt;
    logic w_haz_md;
    logic w_stall;
    logic w_md_busy;

    // A producer only blocks D when its result arrives later than D needs it.
    assign w_haz_rs = (hif.rs_D != 5'd0) &&
                      ((hif.we_E && (hif.wa_E == hif.rs_D) && (hif.tnew_E > hif.tuse_rs_D)) ||
                       (hif.we_M && (hif.wa_M == hif.rs_D) && (hif.tnew_M > hif.tuse_rs_D)));
    assign w_haz_rt = (hif.rt_D != 5'd0) &&
                      ((hif.we_E && (hif.wa_E == hif.rt_D) && (hif.tnew_E > hif.tuse_rt_D)) ||
                       (hif.we_M && (hif.wa_M == hif.rt_D) && (hif.tnew_M > hif.tuse_rt_D)));

    assign w_md_busy = (r_count != 6'd0);
    assign w_haz_md  = hif.md_D && (w_md_busy || hif.md_start_E);
    assign w_stall   = w_haz_rs || w_haz_rt || w_haz_md;

    assign hif.stall   = w_stall;
    assign hif.flush_E = w_stall;
    assign hif.md_busy = w_md_busy;

    always_comb begin
        hif.fwd_rs_D = 2'd0;
        if (hif.we_M && (hif.wa_M == hif.rs_D) && (hif.rs_D != 5'd0) && (hif.tnew_M == 2'd0))
            hif.fwd_rs_D = 2'd1;
        else if (hif.we_W && (hif.wa_W == hif.rs_D) && (hif.rs_D != 5'd0))
            hif.fwd_rs_D = 2'd2;
    end

    always_comb begin
        hif.fwd_rt_D = 2'd0;
        if (hif.we_M && (hif.wa_M == hif.rt_D) && (hif.rt_D != 5'd0) && (hif.tnew_M == 2'd0))
            hif.fwd_rt_D = 2'd1;
        else if (hif.we_W && (hif.wa_W == hif.rt_D) && (hif.rt_D != 5'd0))
            hif.fwd_rt_D = 2'd2;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_count <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Starts arriving while busy are dropped; stall never freezes the count.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (hif.md_start_E) begin
                    w_state_nxt = S_BUSY;
                    w_count_nxt = hif.md_div_E ? 6'd10 : 6'd5;
                end
            end
            S_BUSY: begin
                w_count_nxt = r_count - 6'd1;
                if (r_count == 6'd1)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 6'd0;
            end
        endcase
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            r_stall_cnt <= 32'd0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
